// File: rtl/gpr_file.sv
// General-purpose register file: one write port with in-place LOAD/INC/DEC/CLR,
// a combinational MUX read port and a registered, write-bypassed BUS read port.
module gpr_file #(
  parameter int DATA_W   = 24,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [1:0]        op,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]  mux_sel,
  output logic [DATA_W-1:0] mux_out,
  input  logic              read_bus,
  input  logic [SEL_W-1:0]  bus_sel,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_valid,
  output logic              wr_zero
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_bus_out;
  logic              r_bus_valid;
  logic              r_wr_zero;

  logic              w_wr_ok;
  logic [DATA_W-1:0] w_cur;
  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] w_bus_val;

  function automatic logic sel_ok(input logic [SEL_W-1:0] sel);
    return (int'(sel) < NUM_REGS) && !(ZERO_REG && sel == '0);
  endfunction

  // Unreachable registers (out of range, or hardwired R0) always read as zero.
  function automatic logic [DATA_W-1:0] rd(input logic [SEL_W-1:0] sel);
    if (!sel_ok(sel)) return '0;
    return r_regs[sel];
  endfunction

  always_comb begin
    w_wr_ok = write && sel_ok(wr_sel);
    w_cur   = rd(wr_sel);
    unique case (op)
      OP_LOAD: w_result = data_in;
      OP_INC:  w_result = w_cur + 1'b1;
      OP_DEC:  w_result = w_cur - 1'b1;
      OP_CLR:  w_result = '0;
      default: w_result = '0;
    endcase
    w_bus_val = (w_wr_ok && wr_sel == bus_sel) ? w_result : rd(bus_sel);
    mux_out   = rd(mux_sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is reset explicitly because the control unit relies on all-zero contents after reset.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_bus_out   <= '0;
      r_bus_valid <= 1'b0;
      r_wr_zero   <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_regs[wr_sel] <= w_result;
        r_wr_zero      <= (w_result == '0);
      end
      r_bus_valid <= read_bus;
      r_bus_out   <= read_bus ? w_bus_val : '0;
    end
  end

  assign bus_out   = r_bus_out;
  assign bus_valid = r_bus_valid;
  assign wr_zero   = r_wr_zero;

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: a default instance and a ZERO_REG=1 instance share stimulus.
module tb_gpr_file;

  logic        clk;
  logic        rst;
  logic        write;
  logic [1:0]  op;
  logic [2:0]  wr_sel;
  logic [23:0] data_in;
  logic [2:0]  mux_sel;
  logic        read_bus;
  logic [2:0]  bus_sel;

  logic [23:0] a_mux_out, a_bus_out, b_mux_out, b_bus_out;
  logic        a_bus_valid, a_wr_zero, b_bus_valid, b_wr_zero;

  int tests = 0;
  int fails = 0;

  gpr_file #(.DATA_W(24), .NUM_REGS(8), .SEL_W(3), .ZERO_REG(1'b0)) dut_a (
    .clk(clk), .rst(rst), .write(write), .op(op), .wr_sel(wr_sel), .data_in(data_in),
    .mux_sel(mux_sel), .mux_out(a_mux_out), .read_bus(read_bus), .bus_sel(bus_sel),
    .bus_out(a_bus_out), .bus_valid(a_bus_valid), .wr_zero(a_wr_zero)
  );

  gpr_file #(.DATA_W(24), .NUM_REGS(8), .SEL_W(3), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .rst(rst), .write(write), .op(op), .wr_sel(wr_sel), .data_in(data_in),
    .mux_sel(mux_sel), .mux_out(b_mux_out), .read_bus(read_bus), .bus_sel(bus_sel),
    .bus_out(b_bus_out), .bus_valid(b_bus_valid), .wr_zero(b_wr_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] o, input logic [2:0] sel, input logic [23:0] d);
    write = 1'b1; op = o; wr_sel = sel; data_in = d;
    step();
    write = 1'b0;
  endtask

  initial begin
    rst = 1'b0; write = 1'b0; op = 2'b00; wr_sel = '0; data_in = '0;
    mux_sel = '0; read_bus = 1'b0; bus_sel = '0;

    // 1. reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mux_sel = 3'(i);
      #1;
      check($sformatf("reset_mux_r%0d", i), a_mux_out, 24'h0);
    end
    check("reset_bus_out", a_bus_out, 24'h0);
    check("reset_bus_valid", 24'(a_bus_valid), 24'h0);
    check("reset_wr_zero", 24'(a_wr_zero), 24'h0);

    // 2. load / read
    wr(2'b00, 3'd3, 24'd100);
    mux_sel = 3'd3;
    #1;
    check("load_mux_r3", a_mux_out, 24'd100);
    check("load_wr_zero", 24'(a_wr_zero), 24'h0);
    read_bus = 1'b1; bus_sel = 3'd3;
    step();
    check("bus_r3_data", a_bus_out, 24'd100);
    check("bus_r3_valid", 24'(a_bus_valid), 24'h1);
    read_bus = 1'b0;
    step();
    check("bus_idle_data", a_bus_out, 24'h0);
    check("bus_idle_valid", 24'(a_bus_valid), 24'h0);

    // 3. wrap
    mux_sel = 3'd5;
    wr(2'b00, 3'd5, 24'hFFFFFF);
    check("wrap_load", a_mux_out, 24'hFFFFFF);
    check("wrap_load_zero", 24'(a_wr_zero), 24'h0);
    wr(2'b01, 3'd5, 24'h0);
    check("wrap_inc", a_mux_out, 24'h0);
    check("wrap_inc_zero", 24'(a_wr_zero), 24'h1);
    wr(2'b10, 3'd5, 24'h0);
    check("wrap_dec", a_mux_out, 24'hFFFFFF);
    check("wrap_dec_zero", 24'(a_wr_zero), 24'h0);
    wr(2'b11, 3'd5, 24'h123456);
    check("clr", a_mux_out, 24'h0);
    check("clr_zero", 24'(a_wr_zero), 24'h1);
    wr(2'b10, 3'd3, 24'h0);
    mux_sel = 3'd3;
    #1;
    check("dec_r3", a_mux_out, 24'd99);
    check("dec_r3_zero", 24'(a_wr_zero), 24'h0);
    mux_sel = 3'd5;
    #1;
    check("r5_hold", a_mux_out, 24'h0);

    // 4. bypass
    wr(2'b00, 3'd2, 24'd1);
    mux_sel = 3'd2;
    write = 1'b1; op = 2'b00; wr_sel = 3'd2; data_in = 24'd7;
    read_bus = 1'b1; bus_sel = 3'd2;
    #1;
    check("bypass_mux_before", a_mux_out, 24'd1);
    step();
    check("bypass_mux_after", a_mux_out, 24'd7);
    check("bypass_bus_data", a_bus_out, 24'd7);
    check("bypass_bus_valid", 24'(a_bus_valid), 24'h1);
    op = 2'b01; wr_sel = 3'd2; bus_sel = 3'd3;
    step();
    check("other_bus_data", a_bus_out, 24'd99);
    check("other_inc_mux", a_mux_out, 24'd8);
    write = 1'b0; read_bus = 1'b0;
    step();

    // 5. reset priority
    rst = 1'b1; write = 1'b1; op = 2'b00; wr_sel = 3'd1; data_in = 24'd9;
    read_bus = 1'b1; bus_sel = 3'd1;
    step();
    rst = 1'b0; write = 1'b0; read_bus = 1'b0;
    mux_sel = 3'd1;
    #1;
    check("rstpri_r1", a_mux_out, 24'h0);
    check("rstpri_bus_valid", 24'(a_bus_valid), 24'h0);
    check("rstpri_bus_out", a_bus_out, 24'h0);
    mux_sel = 3'd3;
    #1;
    check("rstpri_r3", a_mux_out, 24'h0);

    // 6. hardwired R0 on dut_b (dut_a as contrast)
    wr(2'b00, 3'd4, 24'h0);
    check("b_zero_set", 24'(b_wr_zero), 24'h1);
    wr(2'b00, 3'd0, 24'd55);
    mux_sel = 3'd0;
    #1;
    check("b_r0_mux", b_mux_out, 24'h0);
    check("b_r0_wr_zero", 24'(b_wr_zero), 24'h1);
    check("a_r0_mux", a_mux_out, 24'd55);
    check("a_r0_wr_zero", 24'(a_wr_zero), 24'h0);
    write = 1'b1; op = 2'b00; wr_sel = 3'd0; data_in = 24'd77;
    read_bus = 1'b1; bus_sel = 3'd0;
    step();
    write = 1'b0; read_bus = 1'b0;
    check("b_r0_bus_data", b_bus_out, 24'h0);
    check("b_r0_bus_valid", 24'(b_bus_valid), 24'h1);
    check("b_r0_wr_zero2", 24'(b_wr_zero), 24'h1);
    check("a_r0_bus_bypass", a_bus_out, 24'd77);
    wr(2'b01, 3'd0, 24'h0);
    check("b_r0_inc_ignored", b_mux_out, 24'h0);
    check("b_r0_inc_zero", 24'(b_wr_zero), 24'h1);
    check("a_r0_inc", a_mux_out, 24'd78);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
